// File: rtl/pipes_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings and MDU types.
package pipes;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    localparam logic [5:0] F6_NOP   = 6'h00;
    localparam logic [5:0] F6_MFHI  = 6'h10;
    localparam logic [5:0] F6_MTHI  = 6'h11;
    localparam logic [5:0] F6_MFLO  = 6'h12;
    localparam logic [5:0] F6_MTLO  = 6'h13;
    localparam logic [5:0] F6_MULT  = 6'h18;
    localparam logic [5:0] F6_MULTU = 6'h19;
    localparam logic [5:0] F6_DIV   = 6'h1A;
    localparam logic [5:0] F6_DIVU  = 6'h1B;
    localparam logic [5:0] F6_ADDU  = 6'h21;
    localparam logic [5:0] F6_SUBU  = 6'h23;
    localparam logic [5:0] F6_AND   = 6'h24;
    localparam logic [5:0] F6_OR    = 6'h25;
    localparam logic [5:0] F6_XOR   = 6'h26;
    localparam logic [5:0] F6_SLT   = 6'h2A;
    localparam logic [5:0] F6_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    typedef enum logic [2:0] {
        MOP_NONE  = 3'd0,
        MOP_MULT  = 3'd1,
        MOP_MULTU = 3'd2,
        MOP_DIV   = 3'd3,
        MOP_DIVU  = 3'd4,
        MOP_MTHI  = 3'd5,
        MOP_MTLO  = 3'd6
    } mdu_op_t;

endpackage

// File: rtl/execute_mdu_stage_mdu.sv
// Multiply/divide unit: owns HI/LO, runs a counted multiply and a restoring divider.
module mdu
    import pipes::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  mdu_op_t           op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              out_free,
    output logic              done,
    output mdu_state_t        state,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_MAX = (MUL_CYCLES > DATA_W) ? MUL_CYCLES : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_t          state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, dvsr_reg, rem_reg, quo_reg;
    logic                sgn_reg;
    logic [DATA_W-1:0]   hi_reg, lo_reg;

    logic [2*DATA_W-1:0] ext_a, ext_b, product;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   rem_next, quo_next, fix_hi, fix_lo, abs_a, abs_b;
    logic                neg_q, neg_r, div_zero, start_signed;

    always_comb begin
        // One multiplier serves both MULT and MULTU: the low 2W bits of the
        // extended product are correct for either signedness.
        ext_a   = sgn_reg ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg} : {{DATA_W{1'b0}}, a_reg};
        ext_b   = sgn_reg ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg} : {{DATA_W{1'b0}}, b_reg};
        product = ext_a * ext_b;

        trial    = {rem_reg, quo_reg[DATA_W-1]} - {1'b0, dvsr_reg};
        rem_next = trial[DATA_W] ? {rem_reg[DATA_W-2:0], quo_reg[DATA_W-1]} : trial[DATA_W-1:0];
        quo_next = {quo_reg[DATA_W-2:0], ~trial[DATA_W]};

        div_zero = (b_reg == '0);
        neg_q    = sgn_reg && (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]);
        neg_r    = sgn_reg && a_reg[DATA_W-1];
        fix_lo   = div_zero ? '1    : (neg_q ? -quo_reg : quo_reg);
        fix_hi   = div_zero ? a_reg : (neg_r ? -rem_reg : rem_reg);

        start_signed = (op == MOP_DIV);
        abs_a = (start_signed && op_a[DATA_W-1]) ? -op_a : op_a;
        abs_b = (start_signed && op_b[DATA_W-1]) ? -op_b : op_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            dvsr_reg  <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            sgn_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MOP_MULT, MOP_MULTU: begin
                                a_reg     <= op_a;
                                b_reg     <= op_b;
                                sgn_reg   <= (op == MOP_MULT);
                                cnt_reg   <= CNT_W'(MUL_CYCLES - 1);
                                state_reg <= MUL;
                            end
                            MOP_DIV, MOP_DIVU: begin
                                a_reg     <= op_a;
                                b_reg     <= op_b;
                                sgn_reg   <= start_signed;
                                dvsr_reg  <= abs_b;
                                quo_reg   <= abs_a;
                                rem_reg   <= '0;
                                cnt_reg   <= CNT_W'(DATA_W - 1);
                                state_reg <= DIV;
                            end
                            MOP_MTHI: hi_reg <= op_a;
                            MOP_MTLO: lo_reg <= op_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (out_free) begin
                        {hi_reg, lo_reg} <= product;
                        state_reg        <= IDLE;
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    if (out_free) begin
                        hi_reg    <= fix_hi;
                        lo_reg    <= fix_lo;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done  = out_free && (((state_reg == MUL) && (cnt_reg == '0)) || (state_reg == FIX));
    assign state = state_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: rtl/execute_mdu_stage.sv
// Execute stage: single-cycle ALU, valid/ready handshake, one-entry output buffer, MDU.
module execute_mdu_stage
    import pipes::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [5:0]        in_func,
    input  logic [DATA_W-1:0] in_src_a,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_wa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_wa,
    output logic              out_reg_write,
    output logic              busy
);

    mdu_state_t        mdu_state;
    mdu_op_t           mdu_op;
    logic [DATA_W-1:0] mdu_hi, mdu_lo, alu_result;
    logic              mdu_done, alu_write, is_long, out_free, accept;

    logic              out_valid_reg, out_reg_write_reg;
    logic [DATA_W-1:0] out_result_reg;
    logic [4:0]        out_wa_reg, mdu_wa_reg;

    assign busy     = (mdu_state != IDLE);
    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = !busy && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_result = '0;
        alu_write  = 1'b0;
        mdu_op     = MOP_NONE;
        if (in_op == OP_ADDI || in_op == OP_ADDIU) begin
            alu_result = in_src_a + in_imm;
            alu_write  = 1'b1;
        end else if (in_op == OP_RTYPE) begin
            case (in_func)
                F6_ADDU:  begin alu_result = in_src_a + in_rd2; alu_write = 1'b1; end
                F6_SUBU:  begin alu_result = in_src_a - in_rd2; alu_write = 1'b1; end
                F6_AND:   begin alu_result = in_src_a & in_rd2; alu_write = 1'b1; end
                F6_OR:    begin alu_result = in_src_a | in_rd2; alu_write = 1'b1; end
                F6_XOR:   begin alu_result = in_src_a ^ in_rd2; alu_write = 1'b1; end
                F6_SLT: begin
                    alu_result = {{(DATA_W-1){1'b0}}, ($signed(in_src_a) < $signed(in_rd2))};
                    alu_write  = 1'b1;
                end
                F6_SLTU: begin
                    alu_result = {{(DATA_W-1){1'b0}}, (in_src_a < in_rd2)};
                    alu_write  = 1'b1;
                end
                F6_MFHI:  begin alu_result = mdu_hi; alu_write = 1'b1; end
                F6_MFLO:  begin alu_result = mdu_lo; alu_write = 1'b1; end
                F6_MTHI:  mdu_op = MOP_MTHI;
                F6_MTLO:  mdu_op = MOP_MTLO;
                F6_MULT:  mdu_op = MOP_MULT;
                F6_MULTU: mdu_op = MOP_MULTU;
                F6_DIV:   mdu_op = MOP_DIV;
                F6_DIVU:  mdu_op = MOP_DIVU;
                default: ;
            endcase
        end
    end

    // Long ops emit their record later, from the MDU, not at acceptance.
    assign is_long = (mdu_op == MOP_MULT) || (mdu_op == MOP_MULTU) ||
                     (mdu_op == MOP_DIV)  || (mdu_op == MOP_DIVU);

    mdu #(
        .DATA_W    (DATA_W),
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (mdu_op != MOP_NONE)),
        .op      (mdu_op),
        .op_a    (in_src_a),
        .op_b    (in_rd2),
        .out_free(out_free),
        .done    (mdu_done),
        .state   (mdu_state),
        .hi      (mdu_hi),
        .lo      (mdu_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg     <= 1'b0;
            out_result_reg    <= '0;
            out_wa_reg        <= '0;
            out_reg_write_reg <= 1'b0;
            mdu_wa_reg        <= '0;
        end else begin
            if (accept && is_long) begin
                mdu_wa_reg <= in_wa;
            end
            // accept and mdu_done are exclusive: accept needs IDLE, done needs MUL/FIX.
            if (accept && !is_long) begin
                out_valid_reg     <= 1'b1;
                out_result_reg    <= alu_result;
                out_wa_reg        <= in_wa;
                out_reg_write_reg <= alu_write;
            end else if (mdu_done) begin
                out_valid_reg     <= 1'b1;
                out_result_reg    <= '0;
                out_wa_reg        <= mdu_wa_reg;
                out_reg_write_reg <= 1'b0;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_result    = out_result_reg;
    assign out_wa        = out_wa_reg;
    assign out_reg_write = out_reg_write_reg;

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Self-checking bench: directed timing cases plus a random stream against a queue-based reference.
module tb_execute_mdu_stage;

    localparam int W  = 32;
    localparam int MC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready, out_reg_write, busy;
    logic [5:0]    in_op, in_func;
    logic [W-1:0]  in_src_a, in_rd2, in_imm, out_result;
    logic [4:0]    in_wa, out_wa;

    always #5 clk = ~clk;

    execute_mdu_stage #(.DATA_W(W), .MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_func      (in_func),
        .in_src_a     (in_src_a),
        .in_rd2       (in_rd2),
        .in_imm       (in_imm),
        .in_wa        (in_wa),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_wa       (out_wa),
        .out_reg_write(out_reg_write),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        wr;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_cmp = 0, n_bad = 0, acc_cnt = 0, rec_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Architectural reference: what the instruction means, HI/LO updated at acceptance.
    function automatic void ref_exec(input logic [5:0] op, input logic [5:0] func,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm,
                                     output logic [31:0] res, output logic wr);
        longint      sa, sb, q, r, ps;
        logic [63:0] pu;
        sa  = $signed(a);
        sb  = $signed(b);
        res = 32'd0;
        wr  = 1'b0;
        if (op == 6'h08 || op == 6'h09) begin
            res = a + imm; wr = 1'b1;
        end else if (op == 6'h00) begin
            case (func)
                6'h21: begin res = a + b; wr = 1'b1; end
                6'h23: begin res = a - b; wr = 1'b1; end
                6'h24: begin res = a & b; wr = 1'b1; end
                6'h25: begin res = a | b; wr = 1'b1; end
                6'h26: begin res = a ^ b; wr = 1'b1; end
                6'h2A: begin res = (sa < sb) ? 32'd1 : 32'd0; wr = 1'b1; end
                6'h2B: begin res = (a < b) ? 32'd1 : 32'd0; wr = 1'b1; end
                6'h10: begin res = m_hi; wr = 1'b1; end
                6'h12: begin res = m_lo; wr = 1'b1; end
                6'h11: m_hi = a;
                6'h13: m_lo = a;
                6'h18: begin ps = sa * sb; {m_hi, m_lo} = ps; end
                6'h19: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; end
                6'h1A: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                end
                6'h1B: begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                end
                default: ;
            endcase
        end
    endfunction

    // Monitor: samples handshakes between edges and scores every drained record.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (out_valid && out_ready) begin
                check_val("rec_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("rec_result", out_result, mon_e.res);
                    check_val("rec_wa", out_wa, mon_e.wa);
                    check_val("rec_reg_write", out_reg_write, mon_e.wr);
                    $display("rec %0d: wa=%0d result=%h reg_write=%b", rec_cnt, out_wa, out_result, out_reg_write);
                    rec_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                ref_exec(in_op, in_func, in_src_a, in_rd2, in_imm, mon_e.res, mon_e.wr);
                mon_e.wa = in_wa;
                exp_q.push_back(mon_e);
                acc_cnt++;
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [5:0] func, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] wa);
        int n;
        @(negedge clk);
        in_op = op; in_func = func; in_src_a = a; in_rd2 = b; in_imm = imm; in_wa = wa;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("issue_ready", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [11:0] pick_op();
        case ($urandom_range(0, 23))
            0:  return {6'h08, 6'h00};
            1:  return {6'h09, 6'h00};
            2:  return {6'h00, 6'h21};
            3:  return {6'h00, 6'h23};
            4:  return {6'h00, 6'h24};
            5:  return {6'h00, 6'h25};
            6:  return {6'h00, 6'h26};
            7:  return {6'h00, 6'h2A};
            8:  return {6'h00, 6'h2B};
            9:  return {6'h00, 6'h10};
            10: return {6'h00, 6'h12};
            11: return {6'h00, 6'h11};
            12: return {6'h00, 6'h13};
            13: return {6'h00, 6'h18};
            14: return {6'h00, 6'h19};
            15: return {6'h00, 6'h1A};
            16: return {6'h00, 6'h1B};
            17: return {6'h00, 6'h00};
            18: return {6'h00, 6'h3F};
            19: return {6'h23, 6'($urandom_range(0, 63))};
            20: return {6'h00, 6'h10};
            21: return {6'h00, 6'h12};
            22: return {6'h00, 6'h2A};
            default: return {6'h00, 6'h21};
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int c, sent, acc_seen, cyc;
        logic [31:0] held;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_func = '0; in_src_a = '0; in_rd2 = '0; in_imm = '0; in_wa = '0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_result", out_result, 0);
        check_val("rst_out_wa", out_wa, 0);
        check_val("rst_reg_write", out_reg_write, 0);
        reset = 1'b0;

        issue(6'h09, 6'h00, 32'h7FFF_FFFF, 32'd0, 32'd1, 5'd1);
        @(negedge clk);
        check_val("addiu_valid", out_valid, 1);
        check_val("addiu_result", out_result, 32'h8000_0000);
        check_val("addiu_reg_write", out_reg_write, 1);

        issue(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2);
        @(negedge clk);
        check_val("slt_result", out_result, 32'd1);
        issue(6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3);
        @(negedge clk);
        check_val("sltu_result", out_result, 32'd0);

        issue(6'h00, 6'h18, 32'hFFFF_FFFE, 32'd3, 32'd0, 5'd4);
        for (int k = 0; k < MC; k++) begin
            @(negedge clk);
            check_val("mul_in_ready_low", in_ready, 0);
            check_val("mul_no_record", out_valid, 0);
        end
        @(negedge clk);
        check_val("mul_record_valid", out_valid, 1);
        check_val("mul_record_write", out_reg_write, 0);
        check_val("mul_idle", busy, 0);
        issue(6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd5);
        @(negedge clk);
        check_val("mfhi_after_mult", out_result, 32'hFFFF_FFFF);
        issue(6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd6);
        @(negedge clk);
        check_val("mflo_after_mult", out_result, 32'hFFFF_FFFA);

        issue(6'h00, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd7);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_val("div_latency", c, W + 1);
        issue(6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd8);
        @(negedge clk);
        check_val("div_lo", out_result, 32'hFFFF_FFFD);
        issue(6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd9);
        @(negedge clk);
        check_val("div_hi", out_result, 32'hFFFF_FFFF);

        issue(6'h00, 6'h1B, 32'd7, 32'd0, 32'd0, 5'd10);
        repeat (W + 3) @(negedge clk);
        issue(6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd11);
        @(negedge clk);
        check_val("divu0_lo", out_result, 32'hFFFF_FFFF);
        issue(6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd12);
        @(negedge clk);
        check_val("divu0_hi", out_result, 32'd7);

        settle();
        out_ready = 1'b0;
        issue(6'h00, 6'h21, 32'd5, 32'd6, 32'd0, 5'd13);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_valid", out_valid, 1);
            check_val("bp_result", out_result, 32'd11);
            check_val("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_op = 6'h00; in_func = 6'h21; in_src_a = 32'd20; in_rd2 = 32'd22; in_wa = 5'd14;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check_val("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_new_valid", out_valid, 1);
        check_val("bp_new_result", out_result, 32'd42);

        settle();
        issue(6'h00, 6'h1B, 32'd1000, 32'd3, 32'd0, 5'd15);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_out_valid", out_valid, 0);
        held = 32'd0;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            held = held | 32'(out_valid);
        end
        check_val("abort_no_record", held, 0);
        issue(6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd16);
        @(negedge clk);
        check_val("abort_hi_zero", out_result, 32'd0);
        issue(6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd17);
        @(negedge clk);
        check_val("abort_lo_zero", out_result, 32'd0);

        settle();
        sent = 0; cyc = 0; acc_seen = acc_cnt;
        while (sent < 500 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && acc_cnt != acc_seen) begin
                in_valid = 1'b0;
                sent++;
            end
            acc_seen = acc_cnt;
            if (!in_valid && sent < 500 && $urandom_range(0, 4) != 0) begin
                {in_op, in_func} = pick_op();
                in_src_a = rnd_val();
                in_rd2   = rnd_val();
                in_imm   = rnd_val();
                in_wa    = 5'($urandom_range(0, 31));
                in_valid = 1'b1;
            end
        end
        check_val("rand_sent", sent, 500);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_val("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
